// File: rtl/matrix_multiplication_kernel_udiv_87ns_24ns_pkg.sv
// Shared definitions for the sequential 87/24-bit unsigned restoring divider.
// Holds the default operand widths and the controller state encoding.
package matrix_multiplication_kernel_udiv_87ns_24ns_pkg;

    localparam int UDIV_DIVIDEND_WIDTH = 87;
    localparam int UDIV_DIVISOR_WIDTH  = 24;
    localparam int UDIV_CNT_WIDTH      = $clog2(UDIV_DIVIDEND_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } udiv_state_e;

    // Quotient reported when the divisor is zero.
    function automatic logic [UDIV_DIVIDEND_WIDTH-1:0] udiv_dbz_quotient();
        return {UDIV_DIVIDEND_WIDTH{1'b1}};
    endfunction

endpackage

// File: rtl/matrix_multiplication_kernel_udiv_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, then subtract the divisor when it fits.
module matrix_multiplication_kernel_udiv_step
    import matrix_multiplication_kernel_udiv_87ns_24ns_pkg::*;
#(
    parameter int DIVISOR_WIDTH = UDIV_DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH-1:0] i_r_in,
    input  logic                     i_bit,
    input  logic [DIVISOR_WIDTH-1:0] i_divisor,
    output logic [DIVISOR_WIDTH-1:0] o_r_out,
    output logic                     o_qbit
);

    logic [DIVISOR_WIDTH:0] w_shift;
    logic [DIVISOR_WIDTH:0] w_div_ext;

    assign w_shift   = {i_r_in, i_bit};
    assign w_div_ext = {1'b0, i_divisor};

    // The compare runs on one extra bit; after a restore the remainder fits back in DIVISOR_WIDTH.
    always_comb begin
        o_r_out = w_shift[DIVISOR_WIDTH-1:0];
        o_qbit  = 1'b0;
        if (w_shift >= w_div_ext) begin
            o_r_out = DIVISOR_WIDTH'(w_shift - w_div_ext);
            o_qbit  = 1'b1;
        end else begin
            o_r_out = w_shift[DIVISOR_WIDTH-1:0];
            o_qbit  = 1'b0;
        end
    end

endmodule

// File: rtl/matrix_multiplication_kernel_udiv_87ns_24ns.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock,
// valid/ready on both sides with a single divide in flight.
module matrix_multiplication_kernel_udiv_87ns_24ns
    import matrix_multiplication_kernel_udiv_87ns_24ns_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = UDIV_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = UDIV_DIVISOR_WIDTH
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH);

    udiv_state_e               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [DIVIDEND_WIDTH-1:0] r_dividend;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic [DIVISOR_WIDTH-1:0]  r_part;
    logic [DIVIDEND_WIDTH-2:0] r_q;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [DIVIDEND_WIDTH-1:0] r_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_remainder;
    logic                      r_dbz;

    logic [DIVISOR_WIDTH-1:0]  w_r_out;
    logic                      w_qbit;

    matrix_multiplication_kernel_udiv_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .i_r_in    (r_part),
        .i_bit     (r_dividend[DIVIDEND_WIDTH-1]),
        .i_divisor (r_divisor),
        .o_r_out   (w_r_out),
        .o_qbit    (w_qbit)
    );

    // Controller, datapath shift registers and registered result outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_dividend  <= {DIVIDEND_WIDTH{1'b0}};
            r_divisor   <= {DIVISOR_WIDTH{1'b0}};
            r_part      <= {DIVISOR_WIDTH{1'b0}};
            r_q         <= {(DIVIDEND_WIDTH-1){1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= {DIVIDEND_WIDTH{1'b0}};
            r_remainder <= {DIVISOR_WIDTH{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dividend <= din0;
                        r_divisor  <= din1;
                        r_part     <= {DIVISOR_WIDTH{1'b0}};
                        r_q        <= {(DIVIDEND_WIDTH-1){1'b0}};
                        r_cnt      <= CNT_W'(DIVIDEND_WIDTH - 1);
                        r_in_ready <= 1'b0;
                        if (din1 == {DIVISOR_WIDTH{1'b0}}) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= BUSY;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    r_part     <= w_r_out;
                    r_dividend <= {r_dividend[DIVIDEND_WIDTH-2:0], 1'b0};
                    r_q        <= {r_q[DIVIDEND_WIDTH-3:0], w_qbit};
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_quotient  <= {r_q, w_qbit};
                        r_remainder <= w_r_out;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    // Divide-by-zero arrives here with out_valid still low; publish one cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_quotient  <= {DIVIDEND_WIDTH{1'b1}};
                        r_remainder <= r_dividend[DIVISOR_WIDTH-1:0];
                        r_dbz       <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_matrix_multiplication_kernel_udiv_87ns_24ns.sv
// Directed scoreboard bench for the 87/24-bit sequential divider.
module tb_matrix_multiplication_kernel_udiv_87ns_24ns;

    logic         ap_clk;
    logic         ap_rst;
    logic         in_valid;
    logic         in_ready;
    logic [86:0]  din0;
    logic [23:0]  din1;
    logic         out_valid;
    logic         out_ready;
    logic [86:0]  quotient;
    logic [23:0]  remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [86:0] q;
        logic [23:0] r;
        logic        dbz;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    matrix_multiplication_kernel_udiv_87ns_24ns dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: push expectation, handshake in, wait, compare, optional backpressure, handshake out.
    // noisy: keep in_valid asserted with junk while busy and across the output handshake.
    task automatic run_op(input logic [86:0] a, input logic [23:0] b, input int hold, input bit noisy);
        exp_t        e;
        exp_t        got;
        logic [86:0] bw;
        logic [86:0] rem_full;
        int          wcnt;
        int          lat;
        bw = {63'd0, b};
        if (b == 24'd0) begin
            e.q   = {87{1'b1}};
            e.r   = a[23:0];
            e.dbz = 1'b1;
            e.lat = 32'd1;
        end else begin
            rem_full = a % bw;
            e.q   = a / bw;
            e.r   = rem_full[23:0];
            e.dbz = 1'b0;
            e.lat = 32'd87;
        end
        sb.push_back(e);

        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        wcnt = 0;
        while (!in_ready && wcnt < 200) begin
            tick();
            wcnt++;
        end
        check("accept_ready", {127'd0, in_ready}, 128'd1);
        tick();
        if (noisy) begin
            din0 = ~a;
            din1 = b + 24'd1;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        got = sb.pop_front();
        check("latency", 128'(lat), 128'(got.lat));
        check("quotient", 128'(quotient), 128'(got.q));
        check("remainder", 128'(remainder), 128'(got.r));
        check("div_by_zero", 128'(div_by_zero), 128'(got.dbz));
        check("in_ready_done", {127'd0, in_ready}, 128'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {127'd0, out_valid}, 128'd1);
            check("hold_quotient", 128'(quotient), 128'(got.q));
            check("hold_remainder", 128'(remainder), 128'(got.r));
            check("hold_in_ready", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("release_valid", {127'd0, out_valid}, 128'd0);
        check("release_ready", {127'd0, in_ready}, 128'd1);
        check("idle_hold_q", 128'(quotient), 128'(got.q));
    endtask

    initial begin
        logic [86:0] prod;
        logic [86:0] ra;
        logic [23:0] rb;
        int          seen;

        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = 87'd0;
        din1      = 24'd0;
        tick();
        tick();
        ap_rst = 1'b0;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_quotient", 128'(quotient), 128'd0);
        check("rst_remainder", 128'(remainder), 128'd0);
        check("rst_dbz", {127'd0, div_by_zero}, 128'd0);

        // out_ready while nothing is valid must not disturb the idle block
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready", {126'd0, in_ready, out_valid}, 128'd2);

        run_op(87'd100, 24'd7, 0, 1'b0);
        check("basic_q_const", 128'(quotient), 128'd14);
        check("basic_r_const", 128'(remainder), 128'd2);

        run_op({87{1'b1}}, 24'd1, 0, 1'b0);
        check("max_div1_q", 128'(quotient), 128'(87'h7F_FFFF_FFFF_FFFF_FFFF_FFFF));
        run_op(87'd5, 24'hFF_FFFF, 0, 1'b0);
        check("small_q_const", 128'(quotient), 128'd0);
        check("small_r_const", 128'(remainder), 128'd5);

        // An exact product that fits in 87 bits recovers its multiplier.
        prod = 87'h00FF_FFFF * 87'h7EAD_BEEF_0123_4567;
        run_op(prod, 24'hFF_FFFF, 0, 1'b0);
        check("roundtrip_q", 128'(quotient), 128'(87'h7EAD_BEEF_0123_4567));
        check("roundtrip_r", 128'(remainder), 128'd0);
        // 0xFFFFFF * 0xDEADBEEF01234567 needs 88 bits; din0 carries its low 87 bits.
        prod = 87'h00FF_FFFF * 87'hDEAD_BEEF_0123_4567;
        run_op(prod, 24'hFF_FFFF, 0, 1'b0);

        run_op(87'h1_2345_6789, 24'd0, 0, 1'b0);
        check("dbz_r_const", 128'(remainder), 128'h45_6789);

        run_op(87'h3_1234_5678_9ABC_DEF0_1357, 24'hA5_5A5A, 10, 1'b0);
        run_op(87'd1_000_003, 24'd1_000_003, 0, 1'b1);
        run_op(87'h0_0000_0000_0000_00AB_CDEF, 24'd0, 3, 1'b1);

        for (int k = 0; k < 4; k++) begin
            ra = {23'($urandom), 32'($urandom), 32'($urandom)};
            rb = 24'($urandom_range(1, 32'h00FF_FFFF));
            run_op(ra, rb, 0, 1'b0);
        end

        // Reset while busy discards the result.
        din0 = 87'd100;
        din1 = 24'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("busy_in_ready", {127'd0, in_ready}, 128'd0);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_result", 128'(seen), 128'd0);

        run_op(87'd1000, 24'd33, 0, 1'b0);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
